// File: rtl/sprite_engine.sv
// Sprite engine: walk/jump motion driven by the vsync tick, plus a two-stage
// pixel pipeline that turns DrawX/DrawY into a sprite-ROM address and then
// into a palette index for the VGA path.
module sprite_engine #(
   parameter int SPR_W     = 32,
   parameter int SPR_H     = 48,
   parameter int FRAMES    = 4,
   parameter int FRAME_DIV = 8,
   parameter int STEP      = 2,
   parameter int JUMP_V    = 12,
   parameter int X_MIN     = 0,
   parameter int X_MAX     = 607,
   parameter int GROUND_Y  = 400,
   parameter int X_INIT    = 100
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        frame_clk,
   input  logic        move_left,
   input  logic        move_right,
   input  logic        jump,
   input  logic [9:0]  DrawX,
   input  logic [9:0]  DrawY,
   output logic [12:0] rom_addr,
   input  logic [7:0]  rom_data,
   output logic        is_character,
   output logic [7:0]  character_data,
   output logic [9:0]  pos_x,
   output logic [9:0]  pos_y
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WALK = 2'd1,
      S_JUMP = 2'd2
   } state_e;

   // All position arithmetic is done 11 bits wide so sums never wrap.
   localparam logic [10:0]        X_MIN11   = 11'(X_MIN);
   localparam logic [10:0]        X_MAX11   = 11'(X_MAX);
   localparam logic [10:0]        STEP11    = 11'(STEP);
   localparam logic signed [10:0] GROUND_S  = 11'(GROUND_Y);
   localparam logic [9:0]         GROUND10  = 10'(GROUND_Y);
   localparam logic [9:0]         X_INIT10  = 10'(X_INIT);
   localparam logic [9:0]         X_MIN10   = 10'(X_MIN);
   localparam logic [9:0]         X_MAX10   = 10'(X_MAX);
   localparam logic signed [6:0]  JUMP_VEL  = 7'(-JUMP_V);
   localparam logic [2:0]         DIV_LAST  = 3'(FRAME_DIV - 1);
   localparam logic [1:0]         FRAME_LAST = 2'(FRAMES - 1);
   localparam logic [10:0]        COL_LAST  = 11'(SPR_W - 1);
   localparam logic [10:0]        ROW_LAST  = 11'(SPR_H - 1);
   localparam logic [12:0]        FRAME_SZ  = 13'(SPR_W * SPR_H);
   localparam logic [12:0]        ROW_SZ    = 13'(SPR_W);

   // Motion state
   state_e             state_q, state_d;
   logic [9:0]         pos_x_q, pos_x_d;
   logic [9:0]         pos_y_q, pos_y_d;
   logic signed [6:0]  vel_q, vel_d;
   logic [1:0]         frame_q, frame_d;
   logic [2:0]         div_q, div_d;
   logic               facing_left_q, facing_left_d;
   logic               frame_clk_q;
   logic               tick;

   // Motion helpers
   logic               one_dir;
   logic               land;
   logic [10:0]        x_plus;
   logic [10:0]        x_cur;
   logic signed [10:0] y_sum;

   // Pixel pipeline
   logic [10:0]        draw_x11, draw_y11, pos_x11, pos_y11;
   logic [10:0]        col_raw, col, row;
   logic               inside_d, inside1_q, inside2_q;
   logic [12:0]        rom_addr_d, rom_addr_q;

   // Rising edge of vsync becomes a one-cycle tick.
   assign tick = frame_clk & ~frame_clk_q;

   // Registered copy of frame_clk for the edge detector.
   always_ff @(posedge Clk or negedge Reset) begin
      // NOTE: every clocked block uses non-blocking assignments so all registers
      // update together from the pre-edge values.
      if (!Reset) frame_clk_q <= 1'b0;
      else        frame_clk_q <= frame_clk;
   end

   // Motion FSM state register.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next state and all per-tick motion/animation updates.
   always_comb begin
      // NOTE: every variable gets a hold default first, so no path leaves one
      // unassigned and no latch can be inferred.
      state_d       = state_q;
      pos_x_d       = pos_x_q;
      pos_y_d       = pos_y_q;
      vel_d         = vel_q;
      frame_d       = frame_q;
      div_d         = div_q;
      facing_left_d = facing_left_q;

      one_dir = move_left ^ move_right;
      x_cur   = {1'b0, pos_x_q};
      x_plus  = x_cur + STEP11;
      y_sum   = $signed({1'b0, pos_y_q}) + {{4{vel_q[6]}}, vel_q};
      land    = (state_q == S_JUMP) && (y_sum >= GROUND_S);

      if (tick) begin
         // Mode selection; a jump request beats walking, the air phase ends on landing.
         unique case (state_q)
            S_IDLE, S_WALK: begin
               if (jump)         state_d = S_JUMP;
               else if (one_dir) state_d = S_WALK;
               else              state_d = S_IDLE;
            end
            S_JUMP: begin
               if (land) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase

         // Horizontal step with saturation at both screen limits.
         if (state_d != S_IDLE && one_dir) begin
            if (move_right) begin
               pos_x_d = (x_plus > X_MAX11) ? X_MAX10 : x_plus[9:0];
            end else begin
               pos_x_d = (x_cur < X_MIN11 + STEP11) ? X_MIN10 : 10'(x_cur - STEP11);
            end
         end

         if (one_dir) facing_left_d = move_left;

         // Ballistic vertical motion; the launch tick only loads the velocity.
         if (state_q == S_JUMP) begin
            if (land) begin
               pos_y_d = GROUND10;
               vel_d   = '0;
            end else begin
               pos_y_d = y_sum[9:0];
               vel_d   = vel_q + 7'sd1;
            end
         end else if (state_d == S_JUMP) begin
            pos_y_d = GROUND10;
            vel_d   = JUMP_VEL;
         end else begin
            pos_y_d = GROUND10;
            vel_d   = '0;
         end

         // Walk cycle advances every FRAME_DIV ticks; any other mode parks it at 0.
         if (state_d == S_WALK) begin
            if (div_q == DIV_LAST) begin
               div_d   = '0;
               frame_d = (frame_q == FRAME_LAST) ? 2'd0 : frame_q + 2'd1;
            end else begin
               div_d = div_q + 3'd1;
            end
         end else begin
            div_d   = '0;
            frame_d = '0;
         end
      end
   end

   // Motion registers; they only move on a tick, i.e. during vertical blank.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         pos_x_q       <= X_INIT10;
         pos_y_q       <= GROUND10;
         vel_q         <= '0;
         frame_q       <= '0;
         div_q         <= '0;
         facing_left_q <= 1'b0;
      end else begin
         pos_x_q       <= pos_x_d;
         pos_y_q       <= pos_y_d;
         vel_q         <= vel_d;
         frame_q       <= frame_d;
         div_q         <= div_d;
         facing_left_q <= facing_left_d;
      end
   end

   // Stage 0: box test and sprite-local coordinates, mirrored when facing left.
   always_comb begin
      draw_x11 = {1'b0, DrawX};
      draw_y11 = {1'b0, DrawY};
      pos_x11  = {1'b0, pos_x_q};
      pos_y11  = {1'b0, pos_y_q};
      inside_d = (draw_x11 >= pos_x11) && (draw_x11 <= pos_x11 + COL_LAST) &&
                 (draw_y11 >= pos_y11) && (draw_y11 <= pos_y11 + ROW_LAST);
      col_raw  = draw_x11 - pos_x11;
      col      = facing_left_q ? (COL_LAST - col_raw) : col_raw;
      row      = draw_y11 - pos_y11;
      rom_addr_d = '0;
      if (inside_d) begin
         rom_addr_d = 13'(frame_q) * FRAME_SZ + 13'(row) * ROW_SZ + 13'(col);
      end
   end

   // Stage 1 registers the ROM address; stage 2 lines the box flag up with ROM data.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         rom_addr_q <= '0;
         inside1_q  <= 1'b0;
         inside2_q  <= 1'b0;
      end else begin
         rom_addr_q <= rom_addr_d;
         inside1_q  <= inside_d;
         inside2_q  <= inside1_q;
      end
   end

   assign rom_addr       = rom_addr_q;
   assign is_character   = inside2_q;
   assign character_data = inside2_q ? rom_data : 8'h00;
   assign pos_x          = pos_x_q;
   assign pos_y          = pos_y_q;

endmodule
